// File: rtl/sign_stage2.sv
// Result-sign stage: resolves the final sign and effective-subtract flag, then holds them with the tag.
// Define SIGN_STAGE2_SKID_EN for a two-entry skid buffer with a registered InReady.
module sign_stage2 #(
    parameter int TAG_W = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [1:0]       OpCode,
    input  logic             SignOperandX,
    input  logic             SignOperandY,
    input  logic             ExclusiveSign,
    input  logic             XMagGE,
    input  logic             ResultZero,
    input  logic [1:0]       RoundMode,
    input  logic [TAG_W-1:0] InTag,
    output logic             OutValid,
    input  logic             OutReady,
    output logic             ResultSign,
    output logic             EffSub,
    output logic [TAG_W-1:0] OutTag,
    output logic [1:0]       Occupancy
);

    localparam int         EW  = TAG_W + 2;
    localparam logic [1:0] RDN = 2'b10;

    logic          w_effSub;
    logic          w_sign;
    logic [EW-1:0] w_entry;
    logic          w_push;
    logic          w_pop;
    logic [EW-1:0] r_main;
    logic          w_unused;

    // The sign of Y only reaches this stage already folded into ExclusiveSign.
    assign w_unused = SignOperandY;

    always_comb begin
        w_effSub = 1'b0;
        w_sign   = SignOperandX;
        if (OpCode[1]) begin
            w_sign = ExclusiveSign;
        end else begin
            w_effSub = ExclusiveSign ^ OpCode[0];
            if (w_effSub) begin
                if (ResultZero)
                    w_sign = (RoundMode == RDN);
                else
                    w_sign = XMagGE ? SignOperandX : ~SignOperandX;
            end
        end
    end

    assign w_entry = {w_sign, w_effSub, InTag};
    assign {ResultSign, EffSub, OutTag} = r_main;

`ifdef SIGN_STAGE2_SKID_EN
    logic [EW-1:0] r_skid;
    logic [1:0]    r_occ;
    logic          r_inReady;
    logic [1:0]    w_nextOcc;

    assign InReady   = r_inReady;
    assign OutValid  = (r_occ != 2'd0);
    assign Occupancy = r_occ;
    assign w_push    = InValid & r_inReady;
    assign w_pop     = OutValid & OutReady;
    assign w_nextOcc = r_occ + {1'b0, w_push} - {1'b0, w_pop};

    // r_main always presents the oldest entry; r_skid catches one extra under backpressure.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_main    <= '0;
            r_skid    <= '0;
            r_occ     <= 2'd0;
            r_inReady <= 1'b0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (w_push)
                        r_main <= w_entry;
                end
                2'd1: begin
                    if (w_push && w_pop)
                        r_main <= w_entry;
                    else if (w_push)
                        r_skid <= w_entry;
                end
                default: begin
                    if (w_pop)
                        r_main <= r_skid;
                end
            endcase
            r_occ     <= w_nextOcc;
            r_inReady <= (w_nextOcc != 2'd2);
        end
    end
`else
    logic r_valid;
    logic r_live;

    // r_live keeps InReady low through reset and for the edge that releases it.
    assign InReady   = r_live & (~r_valid | OutReady);
    assign OutValid  = r_valid;
    assign Occupancy = {1'b0, r_valid};
    assign w_push    = InValid & InReady;
    assign w_pop     = r_valid & OutReady;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_main  <= '0;
            r_valid <= 1'b0;
            r_live  <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_push) begin
                r_main  <= w_entry;
                r_valid <= 1'b1;
            end else if (w_pop) begin
                r_valid <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sign_stage2.sv
// Self-checking bench for sign_stage2: queue-based reference model plus directed literal cases.
// Works with or without SIGN_STAGE2_SKID_EN defined.
module tb_sign_stage2;

    localparam int TAG_W = 4;
`ifdef SIGN_STAGE2_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic             sign;
        logic             eff;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic             Clk = 1'b0;
    logic             Rst = 1'b1;
    logic             InValid = 1'b0;
    logic             InReady;
    logic [1:0]       OpCode = 2'b00;
    logic             SignOperandX = 1'b0;
    logic             SignOperandY = 1'b0;
    logic             ExclusiveSign = 1'b0;
    logic             XMagGE = 1'b0;
    logic             ResultZero = 1'b0;
    logic [1:0]       RoundMode = 2'b00;
    logic [TAG_W-1:0] InTag = '0;
    logic             OutValid;
    logic             OutReady = 1'b0;
    logic             ResultSign;
    logic             EffSub;
    logic [TAG_W-1:0] OutTag;
    logic [1:0]       Occupancy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    entry_t           q[$];
    logic [TAG_W-1:0] outTags[$];
    bit               live = 0;
    bit               cleared = 1;
    bit               started = 0;
    bit               mAccepted = 0;
    bit               mReady;
    bit               mAcc;
    bit               mPop;
    entry_t           lit;

    sign_stage2 #(.TAG_W(TAG_W)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
        .OpCode(OpCode), .SignOperandX(SignOperandX), .SignOperandY(SignOperandY),
        .ExclusiveSign(ExclusiveSign), .XMagGE(XMagGE), .ResultZero(ResultZero),
        .RoundMode(RoundMode), .InTag(InTag), .OutValid(OutValid), .OutReady(OutReady),
        .ResultSign(ResultSign), .EffSub(EffSub), .OutTag(OutTag), .Occupancy(Occupancy)
    );

    always #5 Clk = ~Clk;

    // Reference: ADD/SUB is X + (+/-Y); the sign of the negated-or-not Y decides the real operation.
    function automatic entry_t refEntry(logic [1:0] op, logic sx, logic sy, logic ge,
                                        logic z, logic [1:0] rm, logic [TAG_W-1:0] tag);
        entry_t e;
        logic   syEff;
        e.tag = tag;
        if (op == 2'b10 || op == 2'b11) begin
            e.sign = sx ^ sy;
            e.eff  = 1'b0;
        end else begin
            syEff = (op == 2'b01) ? ~sy : sy;
            e.eff = (sx != syEff);
            if (!e.eff)
                e.sign = sx;
            else if (z)
                e.sign = (rm == 2'b10);
            else
                e.sign = ge ? sx : syEff;
        end
        return e;
    endfunction

    task automatic checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model updates on each edge from the same inputs the DUT sees.
    always @(posedge Clk) begin
        cyc++;
        if (DEPTH == 2)
            mReady = live && (q.size() < 2);
        else
            mReady = live && (q.size() == 0 || OutReady);
        mAcc = InValid && mReady;
        mPop = (q.size() > 0) && OutReady;
        mAccepted = 0;
        if (Rst) begin
            q.delete();
            live    = 0;
            cleared = 1;
        end else begin
            if (mPop) begin
                outTags.push_back(q[0].tag);
                q.delete(0);
            end
            if (mAcc) begin
                q.push_back(refEntry(OpCode, SignOperandX, SignOperandY, XMagGE,
                                     ResultZero, RoundMode, InTag));
                cleared   = 0;
                mAccepted = 1;
            end
            live = 1;
        end
        started = 1;
    end

    always @(negedge Clk) begin
        if (started) begin
            checkOutput("OutValid", OutValid, (q.size() > 0));
            checkOutput("Occupancy", Occupancy, q.size());
            if (DEPTH == 2)
                checkOutput("InReady", InReady, (live && q.size() < 2));
            else
                checkOutput("InReady", InReady, (live && (q.size() == 0 || OutReady)));
            if (q.size() > 0) begin
                checkOutput("ResultSign", ResultSign, q[0].sign);
                checkOutput("EffSub", EffSub, q[0].eff);
                checkOutput("OutTag", OutTag, q[0].tag);
            end else if (cleared) begin
                checkOutput("ResetData", {ResultSign, EffSub, OutTag}, 0);
            end
        end
    end

    task automatic setInputs(logic [1:0] op, logic sx, logic sy, logic ge, logic z,
                             logic [1:0] rm, logic [TAG_W-1:0] tag);
        OpCode        = op;
        SignOperandX  = sx;
        SignOperandY  = sy;
        ExclusiveSign = sx ^ sy;
        XMagGE        = ge;
        ResultZero    = z;
        RoundMode     = rm;
        InTag         = tag;
    endtask

    // Presents one request and waits (bounded) for the model to see it accepted.
    task automatic applyStimulus(logic [1:0] op, logic sx, logic sy, logic ge, logic z,
                                 logic [1:0] rm, logic [TAG_W-1:0] tag);
        bit done = 0;
        setInputs(op, sx, sy, ge, z, rm, tag);
        InValid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge Clk);
            #1;
            done = mAccepted;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got 0 expected 1 (tag %0d)", tag);
        end
    endtask

    task automatic idle(int n);
        InValid = 1'b0;
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int start;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checkOutput("rst_InReady", InReady, 0);
        checkOutput("rst_Occupancy", Occupancy, 0);
        checkOutput("rst_OutValid", OutValid, 0);
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        @(negedge Clk);
        checkOutput("rel_InReady_low", InReady, 0);
        @(negedge Clk);
        checkOutput("rel_InReady_high", InReady, 1);
        @(posedge Clk);
        #1;
        OutReady = 1'b1;

        // Directed cases with hand-computed results
        lit = refEntry(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd5);
        checkOutput("model035", {lit.sign, lit.eff}, 2'b11);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 4'd5);
        InValid = 1'b0;
        @(negedge Clk);
        checkOutput("lit035_valid", OutValid, 1);
        checkOutput("lit035_sign", ResultSign, 1);
        checkOutput("lit035_eff", EffSub, 1);
        checkOutput("lit035_tag", OutTag, 5);
        idle(2);

        lit = refEntry(2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 4'd6);
        checkOutput("model036a", {lit.sign, lit.eff}, 2'b11);
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 4'd6);
        InValid = 1'b0;
        @(negedge Clk);
        checkOutput("lit036a_sign", ResultSign, 1);
        checkOutput("lit036a_eff", EffSub, 1);
        idle(2);
        applyStimulus(2'b01, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 4'd7);
        InValid = 1'b0;
        @(negedge Clk);
        checkOutput("lit036b_sign", ResultSign, 0);
        checkOutput("lit036b_eff", EffSub, 1);
        idle(2);

        lit = refEntry(2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'd8);
        checkOutput("model037", {lit.sign, lit.eff}, 2'b10);
        applyStimulus(2'b10, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 4'd8);
        InValid = 1'b0;
        @(negedge Clk);
        checkOutput("lit037_sign", ResultSign, 1);
        checkOutput("lit037_eff", EffSub, 0);
        idle(3);

        // Backpressure build-up, then ordered drain
        outTags.delete();
        OutReady = 1'b0;
        fork
            begin
                applyStimulus(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 4'd1);
                applyStimulus(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 4'd2);
                applyStimulus(2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'd3);
                InValid = 1'b0;
            end
            begin
                repeat (3) @(posedge Clk);
                @(negedge Clk);
                checkOutput("bp_Occupancy", Occupancy, DEPTH);
                checkOutput("bp_InReady", InReady, 0);
                checkOutput("bp_OutTag", OutTag, 1);
                @(posedge Clk);
                #1;
                OutReady = 1'b1;
            end
        join
        idle(5);
        checkOutput("bp_count", outTags.size(), 3);
        for (int i = 0; i < 3 && i < outTags.size(); i++)
            checkOutput("bp_order", outTags[i], i + 1);

        // Reset while holding entries: nothing stale may come out
        OutReady = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'(9 + i));
        InValid = 1'b0;
        @(negedge Clk);
        checkOutput("prerst_Occupancy", Occupancy, DEPTH);
        outTags.delete();
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        OutReady = 1'b1;
        @(negedge Clk);
        checkOutput("midrst_OutValid", OutValid, 0);
        checkOutput("midrst_Occupancy", Occupancy, 0);
        checkOutput("midrst_InReady", InReady, 0);
        @(negedge Clk);
        checkOutput("midrst_InReady_up", InReady, 1);
        idle(3);
        checkOutput("midrst_no_stale", outTags.size(), 0);

        // Full-rate streaming
        outTags.delete();
        start = cyc;
        for (int i = 0; i < 16; i++)
            applyStimulus(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), 2'($urandom), 4'(i));
        checkOutput("stream_cycles", cyc - start, 16);
        InValid = 1'b0;
        idle(3);
        checkOutput("stream_count", outTags.size(), 16);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            setInputs(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 2'($urandom), 4'($urandom));
            InValid  = ($urandom_range(0, 3) != 0);
            OutReady = ($urandom_range(0, 2) != 0);
            Rst      = ($urandom_range(0, 59) == 0);
            @(posedge Clk);
            #1;
        end
        Rst = 1'b0;
        OutReady = 1'b1;
        idle(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sign_stage2.md
SIGN_STAGE2 -- requirements
Module: sign_stage2

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the operation tag carried alongside the sign.
REQ-002 SHALL have port Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port InValid  input  1  upstream holds a valid sign request.
REQ-005 SHALL have port InReady  output  1  stage accepts a request this cycle.
REQ-006 SHALL have port OpCode  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-007 SHALL have ports SignOperandX, SignOperandY  input  1 each  operand signs.
REQ-008 SHALL have port ExclusiveSign  input  1  SignOperandX ^ SignOperandY from stage 1.
REQ-009 SHALL have port XMagGE  input  1  |X| >= |Y| from the exponent/mantissa comparator.
REQ-010 SHALL have port ResultZero  input  1  magnitude result is exactly zero.
REQ-011 SHALL have port RoundMode  input  2  00 RNE, 01 RTZ, 10 RDN, 11 RUP.
REQ-012 SHALL have port InTag  input  TAG_W  opaque operation tag.
REQ-013 SHALL have port OutValid  output  1  ResultSign/OutTag valid.
REQ-014 SHALL have port OutReady  input  1  downstream accepts this cycle.
REQ-015 SHALL have port ResultSign  output  1  final result sign.
REQ-016 SHALL have port EffSub  output  1  effective operation was subtraction (ADD/SUB only, else 0).
REQ-017 SHALL have port OutTag  output  TAG_W  tag of the presented result.
REQ-018 SHALL have port Occupancy  output  2  number of held entries (0..2).

Function
REQ-019 Transfer in SHALL occur on InValid & InReady; transfer out on OutValid & OutReady.
REQ-020 MUL/DIV: ResultSign SHALL equal ExclusiveSign; EffSub SHALL be 0; ResultZero ignored.
REQ-021 ADD/SUB: effective subtract SHALL be ExclusiveSign ^ OpCode[0].
REQ-022 Effective add, any ResultZero: ResultSign SHALL be SignOperandX.
REQ-023 Effective subtract, ResultZero=0: ResultSign SHALL be SignOperandX if XMagGE else ~SignOperandX.
REQ-024 Effective subtract, ResultZero=1: ResultSign SHALL be 1 when RoundMode=RDN, else 0.
REQ-025 Sign SHALL be computed combinationally at input and registered; latency from accepted input to OutValid SHALL be exactly 1 cycle when the stage is empty.
REQ-026 Entries SHALL leave in acceptance order; OutTag, EffSub, ResultSign SHALL stay stable while OutValid & ~OutReady.
REQ-027 Simultaneous in and out transfer SHALL keep Occupancy unchanged and accept with no bubble.
REQ-028 Occupancy SHALL increment on in-only transfer, decrement on out-only transfer, never exceed the configured depth nor underflow.
REQ-029 InReady SHALL be a register output (no combinational path from OutReady) when SIGN_STAGE2_SKID_EN is defined.

Reset
REQ-030 While Rst=1 at a clock edge: OutValid=0, Occupancy=0, ResultSign=0, EffSub=0, OutTag=0, InReady=0.
REQ-031 InReady SHALL rise the first cycle after Rst deasserts; any in-flight entry SHALL be discarded by reset mid-operation.
REQ-032 Inputs presented during reset SHALL not be accepted.

Configuration
REQ-033 Macro SIGN_STAGE2_SKID_EN defined: two-entry skid buffer (main + skid register); InReady = (Occupancy < 2) registered; full throughput under backpressure.
REQ-034 Macro SIGN_STAGE2_SKID_EN undefined: single output register; InReady = ~OutValid | OutReady (combinational); Occupancy never exceeds 1; functional results identical.

Verification
REQ-035 ADD, Sx=0, Sy=1, XMagGE=0, ResultZero=0, OutReady=1 -> next cycle OutValid=1, ResultSign=1, EffSub=1.
REQ-036 SUB, Sx=1, Sy=1, ResultZero=1, RoundMode=10 then 00 -> ResultSign=1 then 0, EffSub=1 both.
REQ-037 MUL, Sx=1, Sy=0, ExclusiveSign=1, ResultZero=1 -> ResultSign=1, EffSub=0.
REQ-038 Tags 1,2,3 streamed with OutReady held 0 for 3 cycles (skid build) -> InReady=0 at Occupancy=2, outputs stable, then tags 1,2,3 emitted in order when OutReady=1.
REQ-039 Rst pulsed for 1 cycle with Occupancy=2 -> OutValid=0, Occupancy=0 next cycle, InReady=1 cycle after; no stale tag emitted.
REQ-040 Continuous InValid=1, OutReady=1 for 16 ops -> one result per cycle, Occupancy constant 1, in both macro configurations.
